// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x3 keypad column scanner with frame debouncing and one-hot key strobes.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [2:0]  col_out,
  output logic [11:0] key_code,
  output logic        key_valid,
  output logic        key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  typedef enum logic {IDLE, PRESSED} state_t;
  state_t state, state_nx;
  logic [3:0] sync1, row_s;
  logic [DW-1:0] div_cnt;
  logic [1:0] col_idx;
  logic [11:0] raw, raw_nx, frame, last_frame, code_nx;
  logic [SW-1:0] stab_cnt, stab_nx;
  logic sample, done, accepted, single, valid_nx;
  assign sample   = div_cnt == DW'(SCAN_DIV - 1);
  assign done     = sample && col_idx == 2'd2;
  assign col_out  = 3'b001 << col_idx;
  assign key_held = state == PRESSED;
  // raw is kept row-major (bit 3r+c); the bottom row swaps so '0' lands on bit 9 and '*' on bit 10
  always_comb begin
    raw_nx = raw;
    for (int r = 0; r < 4; r++) raw_nx[3*r + int'(col_idx)] = row_s[r];
  end
  assign frame    = {raw_nx[11], raw_nx[9], raw_nx[10], raw_nx[8:0]};
  assign stab_nx  = (frame != last_frame) ? SW'(1) :
                    (stab_cnt == SW'(DEBOUNCE_CNT)) ? stab_cnt : stab_cnt + 1'b1;
  assign accepted = done && stab_nx == SW'(DEBOUNCE_CNT);
  assign single   = frame != '0 && (frame & (frame - 12'd1)) == '0;
  always_comb begin
    state_nx = state;
    code_nx  = key_code;
    valid_nx = 1'b0;
    if (accepted && state == IDLE && single) begin
      state_nx = PRESSED;
      code_nx  = frame;
      valid_nx = 1'b1;
    end else if (accepted && state == PRESSED && frame == '0) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= '0;
      row_s      <= '0;
      div_cnt    <= '0;
      col_idx    <= '0;
      raw        <= '0;
      last_frame <= '0;
      stab_cnt   <= '0;
      state      <= IDLE;
      key_code   <= '0;
      key_valid  <= 1'b0;
    end else begin
      sync1     <= row_in;
      row_s     <= sync1;
      div_cnt   <= sample ? '0 : div_cnt + 1'b1;
      col_idx   <= !sample ? col_idx : (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
      raw       <= sample ? raw_nx : raw;
      last_frame <= done ? frame : last_frame;
      stab_cnt  <= done ? stab_nx : stab_cnt;
      state     <= state_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
    end
  end
endmodule
